// File: rtl/mod_cnt_ctrl_if.sv
// mod_cnt_ctrl_if - bundle of control and status signals for the modulo counter.
//   master : event source (drives vld, clr, dir, ld, ld_val; observes count, active, tc)
//   slave  : the counter itself (consumes the controls, drives the registered status)
// WIDTH must match the WIDTH parameter of the attached mod_cnt_ctrl.
interface mod_cnt_ctrl_if #(
  parameter int WIDTH = 4
) ();
  logic             vld;
  logic             clr;
  logic             dir;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] count;
  logic             active;
  logic             tc;

  modport master (
    output vld, clr, dir, ld, ld_val,
    input  count, active, tc
  );

  modport slave (
    input  vld, clr, dir, ld, ld_val,
    output count, active, tc
  );
endinterface

// File: rtl/mod_cnt_ctrl.sv
// mod_cnt_ctrl - parametrised modulo-N event counter FSM.
// Counts qualified vld events in the range 1..MOD (0 means idle), up or down,
// with parallel load, wrap or saturate behaviour and a one-cycle terminal-count pulse.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : mod_cnt_ctrl_if.slave
//          vld    - count event       clr    - synchronous clear
//          dir    - 1 up / 0 down     ld     - synchronous load
//          ld_val - load value        count  - registered count
//          active - registered, state != IDLE
//          tc     - registered terminal-count pulse
// WIDTH sets the width of count and ld_val; the upper end of the count range is
// given by the modulus parameter (at least 2, at most 2^WIDTH-1); SATURATE picks
// wrapping at the range ends (0) or stopping at the range end in DONE (1).
module mod_cnt_ctrl #(
  parameter int WIDTH    = 4,
  parameter int MOD      = 10,
  parameter bit SATURATE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  mod_cnt_ctrl_if.slave      bus
);

  if (MOD < 2 || MOD > (2 ** WIDTH) - 1) begin : g_bad_mod
    $error("mod_cnt_ctrl: MOD must satisfy 2 <= MOD <= 2^WIDTH-1");
  end

  localparam logic [WIDTH-1:0] ZERO   = '0;
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO    = WIDTH'(2);
  localparam logic [WIDTH-1:0] MOD_W  = WIDTH'(MOD);
  localparam logic [WIDTH-1:0] MOD_M1 = WIDTH'(MOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] next_count;
  logic             active_q;
  logic             tc_q;
  logic             next_tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count_q  <= ZERO;
      active_q <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state    <= next_state;
      count_q  <= next_count;
      active_q <= (next_state != IDLE);
      tc_q     <= next_tc;
    end
  end

  // Priority is clr > ld > vld; an unreachable state code (including DONE when
  // saturation is disabled) falls back to IDLE so the counter cannot lock up.
  always_comb begin
    next_state = state;
    next_count = count_q;
    next_tc    = 1'b0;

    if (bus.clr) begin
      next_state = IDLE;
      next_count = ZERO;
    end else if (bus.ld) begin
      if (bus.ld_val == ZERO) begin
        next_state = IDLE;
        next_count = ZERO;
      end else if (bus.ld_val > MOD_W) begin
        next_state = ACTIVE;
        next_count = MOD_W;
      end else begin
        next_state = ACTIVE;
        next_count = bus.ld_val;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.vld) begin
            next_state = ACTIVE;
            next_count = bus.dir ? ONE : MOD_W;
          end
        end

        ACTIVE: begin
          if (bus.vld) begin
            if (bus.dir) begin
              if (SATURATE) begin
                // Reaching MOD, or already sitting on it after a load, ends the run.
                if (count_q >= MOD_M1) begin
                  next_count = MOD_W;
                  next_tc    = 1'b1;
                  next_state = DONE;
                end else begin
                  next_count = count_q + ONE;
                end
              end else begin
                if (count_q >= MOD_W) begin
                  next_count = ONE;
                  next_tc    = 1'b1;
                end else begin
                  next_count = count_q + ONE;
                end
              end
            end else begin
              if (SATURATE) begin
                if (count_q <= TWO) begin
                  next_count = ONE;
                  next_tc    = 1'b1;
                  next_state = DONE;
                end else begin
                  next_count = count_q - ONE;
                end
              end else begin
                if (count_q <= ONE) begin
                  next_count = MOD_W;
                  next_tc    = 1'b1;
                end else begin
                  next_count = count_q - ONE;
                end
              end
            end
          end
        end

        DONE: begin
          if (!SATURATE) begin
            next_state = IDLE;
            next_count = ZERO;
          end
        end

        default: begin
          next_state = IDLE;
          next_count = ZERO;
        end
      endcase
    end
  end

  assign bus.count  = count_q;
  assign bus.active = active_q;
  assign bus.tc     = tc_q;

endmodule

// File: tb/tb_mod_cnt_ctrl.sv
// tb_mod_cnt_ctrl - self-checking bench for mod_cnt_ctrl.
// Three instances (MOD=3 wrap, MOD=10 wrap, MOD=10 saturate) share the same
// stimulus; each is tracked by a behavioural model and checked every cycle,
// and the directed scenarios add literal checks on the instance they target.
module tb_mod_cnt_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic       clr = 1'b0;
  logic       dir = 1'b0;
  logic       ld  = 1'b0;
  logic [3:0] ld_val = 4'd0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mod_cnt_ctrl_if #(.WIDTH(4)) if_a ();
  mod_cnt_ctrl_if #(.WIDTH(4)) if_b ();
  mod_cnt_ctrl_if #(.WIDTH(4)) if_c ();

  assign if_a.vld = vld;  assign if_a.clr = clr;  assign if_a.dir = dir;
  assign if_a.ld  = ld;   assign if_a.ld_val = ld_val;
  assign if_b.vld = vld;  assign if_b.clr = clr;  assign if_b.dir = dir;
  assign if_b.ld  = ld;   assign if_b.ld_val = ld_val;
  assign if_c.vld = vld;  assign if_c.clr = clr;  assign if_c.dir = dir;
  assign if_c.ld  = ld;   assign if_c.ld_val = ld_val;

  mod_cnt_ctrl #(.WIDTH(4), .MOD(3),  .SATURATE(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  mod_cnt_ctrl #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  mod_cnt_ctrl #(.WIDTH(4), .MOD(10), .SATURATE(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  logic [3:0] obs_cnt [3];
  logic       obs_act [3];
  logic       obs_tc  [3];
  assign obs_cnt[0] = if_a.count;  assign obs_act[0] = if_a.active;  assign obs_tc[0] = if_a.tc;
  assign obs_cnt[1] = if_b.count;  assign obs_act[1] = if_b.active;  assign obs_tc[1] = if_b.tc;
  assign obs_cnt[2] = if_c.count;  assign obs_act[2] = if_c.active;  assign obs_tc[2] = if_c.tc;

  // Reference model: count 0 means idle, done marks a saturated run.
  int mods [3] = '{3, 10, 10};
  bit sats [3] = '{1'b0, 1'b0, 1'b1};
  int m_cnt  [3] = '{0, 0, 0};
  bit m_done [3] = '{1'b0, 1'b0, 1'b0};
  bit m_tc   [3] = '{1'b0, 1'b0, 1'b0};

  task automatic model_step(input int mod, input bit sat, inout int cnt,
                            inout bit done, output bit tc);
    tc = 1'b0;
    if (clr) begin
      cnt = 0; done = 1'b0;
    end else if (ld) begin
      cnt = (int'(ld_val) > mod) ? mod : int'(ld_val);
      done = 1'b0;
    end else if (vld) begin
      if (cnt == 0) begin
        cnt = dir ? 1 : mod;
      end else if (done) begin
        // frozen until clr or ld
      end else if (sat) begin
        if (dir) begin
          if (cnt + 1 >= mod) begin cnt = mod; tc = 1'b1; done = 1'b1; end
          else cnt = cnt + 1;
        end else begin
          if (cnt - 1 <= 1) begin cnt = 1; tc = 1'b1; done = 1'b1; end
          else cnt = cnt - 1;
        end
      end else begin
        if (dir) begin
          tc  = (cnt == mod);
          cnt = (cnt % mod) + 1;
        end else begin
          tc  = (cnt == 1);
          cnt = ((cnt - 2 + mod) % mod) + 1;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_done[i] = 1'b0; m_tc[i] = 1'b0;
    end
  endtask

  // Advance one clock, update the models with the inputs just sampled and
  // compare every instance against its model.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_cnt[i] = 0; m_done[i] = 1'b0; m_tc[i] = 1'b0;
      end else begin
        model_step(mods[i], sats[i], m_cnt[i], m_done[i], m_tc[i]);
      end
      n_checks += 3;
      if (obs_cnt[i] !== 4'(m_cnt[i])) begin
        n_fail++;
        $display("[TB] FAIL model_count[%0d] t=%0t got %0d expected %0d", i, $time, obs_cnt[i], m_cnt[i]);
      end
      if (obs_act[i] !== (m_cnt[i] != 0)) begin
        n_fail++;
        $display("[TB] FAIL model_active[%0d] t=%0t got %b expected %b", i, $time, obs_act[i], (m_cnt[i] != 0));
      end
      if (obs_tc[i] !== m_tc[i]) begin
        n_fail++;
        $display("[TB] FAIL model_tc[%0d] t=%0t got %b expected %b", i, $time, obs_tc[i], m_tc[i]);
      end
    end
  endtask

  task automatic set_in(input logic c, input logic l, input logic v, input logic d, input logic [3:0] lv);
    clr = c; ld = l; vld = v; dir = d; ld_val = lv;
  endtask

  task automatic test_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks += 3;
    if (if_a.count !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_count got %0d expected 0", if_a.count); end
    if (if_a.active !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_active got %b expected 0", if_a.active); end
    if (if_a.tc !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tc got %b expected 0", if_a.tc); end
  endtask

  task automatic test_wrap_up();
    int exp_c [7] = '{1, 2, 3, 1, 2, 3, 1};
    bit exp_t [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    for (int k = 0; k < 7; k++) begin
      tick();
      n_checks += 3;
      if (if_a.count !== 4'(exp_c[k])) begin n_fail++; $display("[TB] FAIL wrap_up_count step %0d got %0d expected %0d", k, if_a.count, exp_c[k]); end
      if (if_a.tc !== exp_t[k]) begin n_fail++; $display("[TB] FAIL wrap_up_tc step %0d got %b expected %b", k, if_a.tc, exp_t[k]); end
      if (if_a.active !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_up_active step %0d got %b expected 1", k, if_a.active); end
    end
  endtask

  task automatic test_wrap_down();
    int exp_c [4] = '{3, 2, 1, 3};
    bit exp_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks += 2;
      if (if_a.count !== 4'(exp_c[k])) begin n_fail++; $display("[TB] FAIL wrap_down_count step %0d got %0d expected %0d", k, if_a.count, exp_c[k]); end
      if (if_a.tc !== exp_t[k]) begin n_fail++; $display("[TB] FAIL wrap_down_tc step %0d got %b expected %b", k, if_a.tc, exp_t[k]); end
    end
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    n_checks += 3;
    if (if_a.count !== 4'd0) begin n_fail++; $display("[TB] FAIL clr_vld_count got %0d expected 0", if_a.count); end
    if (if_a.active !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_vld_active got %b expected 0", if_a.active); end
    if (if_a.tc !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_vld_tc got %b expected 0", if_a.tc); end
  endtask

  task automatic test_saturate_up();
    int exp_c [4] = '{9, 10, 10, 10};
    bit exp_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd8);
    tick();
    n_checks += 1;
    if (if_c.count !== 4'd8) begin n_fail++; $display("[TB] FAIL sat_load_count got %0d expected 8", if_c.count); end
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks += 3;
      if (if_c.count !== 4'(exp_c[k])) begin n_fail++; $display("[TB] FAIL sat_up_count step %0d got %0d expected %0d", k, if_c.count, exp_c[k]); end
      if (if_c.tc !== exp_t[k]) begin n_fail++; $display("[TB] FAIL sat_up_tc step %0d got %b expected %b", k, if_c.tc, exp_t[k]); end
      if (if_c.active !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_up_active step %0d got %b expected 1", k, if_c.active); end
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    n_checks += 1;
    if (if_c.count !== 4'd0) begin n_fail++; $display("[TB] FAIL sat_clr_count got %0d expected 0", if_c.count); end
  endtask

  task automatic test_load();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd14);
    tick();
    n_checks += 2;
    if (if_b.count !== 4'd10) begin n_fail++; $display("[TB] FAIL load_clamp_count got %0d expected 10", if_b.count); end
    if (if_b.tc !== 1'b0) begin n_fail++; $display("[TB] FAIL load_clamp_tc got %b expected 0", if_b.tc); end
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    n_checks += 2;
    if (if_b.count !== 4'd0) begin n_fail++; $display("[TB] FAIL load_zero_count got %0d expected 0", if_b.count); end
    if (if_b.active !== 1'b0) begin n_fail++; $display("[TB] FAIL load_zero_active got %b expected 0", if_b.active); end
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
    tick();
    n_checks += 2;
    if (if_b.count !== 4'd5) begin n_fail++; $display("[TB] FAIL load_vld_count got %0d expected 5", if_b.count); end
    if (if_b.active !== 1'b1) begin n_fail++; $display("[TB] FAIL load_vld_active got %b expected 1", if_b.active); end
  endtask

  task automatic test_async_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    tick();
    n_checks += 1;
    if (if_a.count !== 4'd2) begin n_fail++; $display("[TB] FAIL async_pre_count got %0d expected 2", if_a.count); end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks += 4;
    if (if_a.count !== 4'd0) begin n_fail++; $display("[TB] FAIL async_count got %0d expected 0", if_a.count); end
    if (if_a.active !== 1'b0) begin n_fail++; $display("[TB] FAIL async_active got %b expected 0", if_a.active); end
    if (if_a.tc !== 1'b0) begin n_fail++; $display("[TB] FAIL async_tc got %b expected 0", if_a.tc); end
    if (if_c.count !== 4'd0) begin n_fail++; $display("[TB] FAIL async_count_c got %0d expected 0", if_c.count); end
    #1;
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    n_checks += 1;
    if (if_a.count !== 4'd1) begin n_fail++; $display("[TB] FAIL async_restart_count got %0d expected 1", if_a.count); end
  endtask

  task automatic test_done_down();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    n_checks += 1;
    if (if_c.count !== 4'd2) begin n_fail++; $display("[TB] FAIL done_dn_step got %0d expected 2", if_c.count); end
    tick();
    n_checks += 2;
    if (if_c.count !== 4'd1) begin n_fail++; $display("[TB] FAIL done_dn_count got %0d expected 1", if_c.count); end
    if (if_c.tc !== 1'b1) begin n_fail++; $display("[TB] FAIL done_dn_tc got %b expected 1", if_c.tc); end
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks += 3;
      if (if_c.count !== 4'd1) begin n_fail++; $display("[TB] FAIL done_hold_count step %0d got %0d expected 1", k, if_c.count); end
      if (if_c.tc !== 1'b0) begin n_fail++; $display("[TB] FAIL done_hold_tc step %0d got %b expected 0", k, if_c.tc); end
      if (if_c.active !== 1'b1) begin n_fail++; $display("[TB] FAIL done_hold_active step %0d got %b expected 1", k, if_c.active); end
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    tick();
    n_checks += 1;
    if (if_c.count !== 4'd4) begin n_fail++; $display("[TB] FAIL done_reload_count got %0d expected 4", if_c.count); end
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    n_checks += 1;
    if (if_c.count !== 4'd5) begin n_fail++; $display("[TB] FAIL done_reload_inc got %0d expected 5", if_c.count); end
  endtask

  // Random traffic with a sticky direction so that saturation and wrap
  // boundaries are actually reached; only the models judge these cycles.
  task automatic test_back_to_back();
    logic d = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(4) == 0) d = ~d;
      set_in(($urandom_range(19) == 0),
             ($urandom_range(9) == 0),
             ($urandom_range(9) < 7),
             d,
             4'($urandom_range(15)));
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate_up();
    test_load();
    test_async_reset();
    test_done_down();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
